imem_sched: RTL and testbench
=============================

# imem_sched

Scheduler for the instruction memory port shared between the fetch unit and the UART program loader. In RUN mode it forwards fetch reads to the single-port instruction RAM. On a load request it holds the core, takes a length-prefixed byte stream from the UART receiver, packs it into 32-bit words and writes them from address 0. It then pulses a core restart so the PC restarts at 0.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the instruction memory (depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_req  in  1  level from mode switch; a rising edge while in RUN starts a load
- ld_valid  in  1  UART byte valid
- ld_byte  in  8  UART byte
- ld_ready  out  1  byte accepted when ld_valid & ld_ready
- ld_overflow  out  1  sticky: stream longer than memory depth; cleared at next load start
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_W  fetch word address (pc[ADDR_W+1:2])
- fetch_valid  out  1  fetch_data is valid this cycle
- fetch_data  out  32  instruction word (mem_rdata passthrough)
- cpu_hold  out  1  core must hold its PC and suppress state writes
- cpu_restart  out  1  one-cycle pulse; core resets PC to 0
- mem_addr  out  ADDR_W  memory word address
- mem_we  out  1  memory write enable (registered)
- mem_wdata  out  32  memory write data (registered)
- mem_rdata  in  32  memory read data, 1-cycle synchronous latency

## Operation
- States: RUN, HDR_LO, HDR_HI, DATA, FINISH.
- RUN:
  - mem_addr = fetch_addr (combinational); mem_we = 0.
  - fetch_valid = fetch_req registered one cycle.
  - cpu_hold = 0; ld_ready = 0.
  - load_req rising edge (edge detector register reset to 0) -> HDR_LO; clears ld_overflow, word index, byte lane.
- HDR_LO / HDR_HI:
  - ld_ready = 1.
  - Each accepted byte fills count[7:0] then count[15:8] (little-endian).
  - In HDR_HI, on accept: if the 16-bit count == 0 -> FINISH, else -> DATA.
- DATA:
  - ld_ready = 1.
  - Bytes packed little-endian: the first byte goes to [7:0].
  - On the 4th byte: the next cycle carries mem_we = 1, mem_wdata = packed word, mem_addr = word index.
  - Word index increments and remaining count decrements at that 4th-byte handshake.
  - If word index has reached 2^ADDR_W, mem_we stays 0 and ld_overflow sets; bytes are still consumed.
  - Remaining hits 0 -> FINISH.
- FINISH: one cycle. Carries the final write if one is pending. cpu_restart = 1, cpu_hold = 1. -> RUN.
- cpu_hold = 1 in every state except RUN. fetch_valid = 0 outside RUN; fetch_req is ignored there.
- load_req deasserting mid-load has no effect. Only rst aborts a load; memory keeps the partially written words.
- rst: state RUN, mem_we 0, mem_wdata 0, cpu_hold 0, cpu_restart 0, fetch_valid 0, ld_ready 0, ld_overflow 0, counters 0.

## Timing
- Fetch latency: fetch_req at cycle t -> fetch_valid and fetch_data at t+1.
- Sustains one fetch per cycle with no bubbles in RUN.
- Loader throughput: one byte per cycle. ld_ready is never deasserted inside HDR_LO/HDR_HI/DATA.
- Write for word k appears exactly 1 cycle after its 4th byte handshake. Back-to-back words give writes spaced by byte arrival, minimum 4 cycles.
- RUN -> HDR_LO occurs the cycle after the load_req edge is sampled.
- FINISH -> RUN takes one cycle; fetch_valid can first assert 2 cycles after FINISH.
- A fetch_req in the same cycle as the load_req edge still returns fetch_valid next cycle (that read was issued in RUN).

## Structure
- Package imem_pkg:
  - state enum imem_state_t
  - HDR_BYTES = 2, BYTES_PER_WORD = 4
  - default ADDR_W
- Sub-module byte_packer:
  - 2-bit lane counter and 32-bit shift/fill register
  - emits word_valid on the 4th byte
  - synchronous clear input for load start
- Top-level imem_sched holds the FSM, count/index counters, overflow flag and the memory port mux.

## Test plan
- Reset then fetch_req=1 with fetch_addr 0,1,2 on consecutive cycles (mem preloaded 0x13,0x93,0x113) -> fetch_valid=1 from the next cycle with data 0x13, 0x93, 0x113 in order; cpu_hold=0 throughout.
- load_req edge, stream 02 00 | 78 56 34 12 | EF BE AD DE -> mem writes addr0=0x12345678, addr1=0xDEADBEEF; one cpu_restart pulse; cpu_hold high from HDR_LO through FINISH; back to RUN.
- Header 00 00 -> HDR_LO, HDR_HI, FINISH, RUN; no mem_we; single cpu_restart pulse.
- ADDR_W=2 with count 5 -> words 0–3 written, 5th word consumed without write, ld_overflow=1 until the next load_req edge.
- rst asserted mid-DATA after 2 of 4 bytes -> next cycle state RUN, cpu_hold=0, mem_we=0, no write of the partial word; prior words retained.
- ld_valid gaps of 3 idle cycles between bytes -> identical written words; the write lands 1 cycle after each 4th byte; fetch_req during the load gives fetch_valid=0.

Source files
------------

// File: rtl/imem_sched_pkg.sv
// imem_pkg: shared types and constants for the instruction memory scheduler
package imem_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {RUN, HDR_LO, HDR_HI, DATA, FINISH} imem_state_t;
endpackage

// File: rtl/imem_sched_if.sv
// imem_sched_if: fetch, loader, core-control and memory port signals of imem_sched
interface imem_sched_if #(parameter int ADDR_W = imem_pkg::DEF_ADDR_W);
  logic load_req, ld_valid, ld_ready, ld_overflow;
  logic [7:0] ld_byte;
  logic fetch_req, fetch_valid;
  logic [ADDR_W-1:0] fetch_addr, mem_addr;
  logic [31:0] fetch_data, mem_wdata, mem_rdata;
  logic cpu_hold, cpu_restart, mem_we;
  modport slave(
    input load_req, ld_valid, ld_byte, fetch_req, fetch_addr, mem_rdata,
    output ld_ready, ld_overflow, fetch_valid, fetch_data, cpu_hold, cpu_restart, mem_addr, mem_we, mem_wdata
  );
  modport master(
    output load_req, ld_valid, ld_byte, fetch_req, fetch_addr, mem_rdata,
    input ld_ready, ld_overflow, fetch_valid, fetch_data, cpu_hold, cpu_restart, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_sched_byte_packer.sv
// byte_packer: packs a byte stream little-endian into 32-bit words
module byte_packer import imem_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] lane;
  logic [23:0] sr;
  // only the first three bytes are stored; the fourth completes the word combinationally
  assign word_valid = en && lane == 2'(BYTES_PER_WORD - 1);
  assign word = {din, sr};
  always_ff @(posedge clk)
    if (rst || clr) begin
      lane <= 2'd0;
      sr <= 24'd0;
    end else if (en) begin
      lane <= lane + 2'd1;
      sr <= {din, sr[23:8]};
    end
endmodule

// File: rtl/imem_sched.sv
// imem_sched: shares the instruction RAM port between fetch and the UART program loader
module imem_sched import imem_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) (
  input logic clk,
  input logic rst,
  imem_sched_if.slave bus
);
  imem_state_t state;
  logic lreq_q, start, acc, word_valid;
  logic [15:0] cnt;
  logic [ADDR_W:0] idx;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] word;
  assign start = state == RUN && bus.load_req && !lreq_q;
  assign acc = bus.ld_valid && bus.ld_ready;
  assign bus.ld_ready = state inside {HDR_LO, HDR_HI, DATA};
  assign bus.cpu_hold = state != RUN;
  assign bus.cpu_restart = state == FINISH;
  assign bus.mem_addr = state == RUN ? bus.fetch_addr : waddr;
  assign bus.fetch_data = bus.mem_rdata;
  byte_packer u_pack (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .en(acc && state == DATA),
    .din(bus.ld_byte),
    .word_valid(word_valid),
    .word(word)
  );
  // idx has one extra bit so a full memory is distinguishable from index 0
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      lreq_q <= 1'b0;
      cnt <= 16'd0;
      idx <= '0;
      waddr <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= 32'd0;
      bus.fetch_valid <= 1'b0;
      bus.ld_overflow <= 1'b0;
    end else begin
      lreq_q <= bus.load_req;
      bus.fetch_valid <= state == RUN && bus.fetch_req;
      bus.mem_we <= word_valid && !idx[ADDR_W];
      if (word_valid) begin
        bus.mem_wdata <= word;
        waddr <= idx[ADDR_W-1:0];
      end
      case (state)
        RUN: if (start) begin
          state <= HDR_LO;
          idx <= '0;
          bus.ld_overflow <= 1'b0;
        end
        HDR_LO: if (acc) begin
          cnt[7:0] <= bus.ld_byte;
          state <= HDR_HI;
        end
        HDR_HI: if (acc) begin
          cnt[15:8] <= bus.ld_byte;
          state <= {bus.ld_byte, cnt[7:0]} == 16'd0 ? FINISH : DATA;
        end
        DATA: if (word_valid) begin
          cnt <= cnt - 16'd1;
          if (idx[ADDR_W]) bus.ld_overflow <= 1'b1;
          else idx <= idx + 1'b1;
          if (cnt == 16'd1) state <= FINISH;
        end
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_imem_sched.sv
// tb_imem_sched: randomized program loads checked against a word-level memory model
module tb_imem_sched;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic [31:0] ram [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] words [8];
  int checks = 0, errors = 0, nwr = 0, nrs = 0, exp_wr = 0, exp_rs = 0;

  imem_sched_if #(.ADDR_W(AW)) bus();
  imem_sched #(.ADDR_W(AW)) dut(.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h13 + 32'h80 * i;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) nwr++;
    if (bus.cpu_restart === 1'b1) nrs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.ld_valid = 1'b0;
      bus.fetch_req = 1'b1;
      bus.fetch_addr = AW'($urandom);
      step;
      chk("gap_fv", 32'(bus.fetch_valid), 32'd0);
      chk("gap_rdy", 32'(bus.ld_ready), 32'd1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("rdy", 32'(bus.ld_ready), 32'd1);
    chk("hold", 32'(bus.cpu_hold), 32'd1);
    bus.ld_valid = 1'b1;
    bus.ld_byte = b;
    bus.fetch_req = 1'($urandom);
    step;
    bus.ld_valid = 1'b0;
  endtask

  task automatic fetch_seq;
    for (int a = 0; a < DEPTH; a++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_addr = AW'(a);
      step;
      chk("fv", 32'(bus.fetch_valid), 32'd1);
      chk("fd", bus.fetch_data, exp_mem[a]);
      chk("run_hold", 32'(bus.cpu_hold), 32'd0);
    end
    bus.fetch_req = 1'b0;
    step;
    chk("fv_idle", 32'(bus.fetch_valid), 32'd0);
  endtask

  task automatic post(input logic ovf);
    chk("ovf", 32'(bus.ld_overflow), 32'(ovf));
    chk("nwr", nwr, exp_wr);
    chk("nrs", nrs, exp_rs);
    fetch_seq;
    chk("ovf_sticky", 32'(bus.ld_overflow), 32'(ovf));
  endtask

  function automatic int gap(input int gmax, input bit fixed);
    return fixed ? gmax : int'($urandom_range(0, gmax));
  endfunction

  task automatic run_load(input int n, input int gmax, input bit fixed, input int abort_at);
    int nb;
    nb = 0;
    bus.load_req = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = '0;
    step;
    chk("edge_fv", 32'(bus.fetch_valid), 32'd1);
    chk("start_hold", 32'(bus.cpu_hold), 32'd1);
    chk("ovf_clr", 32'(bus.ld_overflow), 32'd0);
    bus.load_req = 1'($urandom);
    send_byte(n[7:0]);
    idle(gap(gmax, fixed));
    send_byte(n[15:8]);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) begin
        idle(gap(gmax, fixed));
        if (nb == abort_at) begin
          rst = 1'b1;
          bus.load_req = 1'b0;
          step;
          chk("rst_hold", 32'(bus.cpu_hold), 32'd0);
          chk("rst_we", 32'(bus.mem_we), 32'd0);
          chk("rst_rdy", 32'(bus.ld_ready), 32'd0);
          chk("rst_wd", bus.mem_wdata, 32'd0);
          rst = 1'b0;
          post(1'b0);
          return;
        end
        send_byte(words[k][8*j +: 8]);
        nb++;
        if (j == 3) begin
          chk("we", 32'(bus.mem_we), 32'(k < DEPTH));
          if (k < DEPTH) begin
            chk("wa", 32'(bus.mem_addr), k);
            chk("wd", bus.mem_wdata, words[k]);
            exp_mem[k] = words[k];
            exp_wr++;
          end
        end
      end
    chk("rs", 32'(bus.cpu_restart), 32'd1);
    chk("fin_hold", 32'(bus.cpu_hold), 32'd1);
    exp_rs++;
    bus.fetch_req = 1'b1;
    step;
    chk("rs_end", 32'(bus.cpu_restart), 32'd0);
    chk("end_hold", 32'(bus.cpu_hold), 32'd0);
    chk("fin_fv", 32'(bus.fetch_valid), 32'd0);
    bus.fetch_req = 1'b0;
    bus.load_req = 1'b0;
    post(n > DEPTH);
  endtask

  task automatic fill;
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load_req = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_byte = 8'd0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h13 + 32'h80 * i;
    step;
    step;
    preload = 1'b0;
    chk("rst_hold0", 32'(bus.cpu_hold), 32'd0);
    chk("rst_rs0", 32'(bus.cpu_restart), 32'd0);
    chk("rst_fv0", 32'(bus.fetch_valid), 32'd0);
    chk("rst_rdy0", 32'(bus.ld_ready), 32'd0);
    chk("rst_ovf0", 32'(bus.ld_overflow), 32'd0);
    chk("rst_we0", 32'(bus.mem_we), 32'd0);
    chk("rst_wd0", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    step;
    fetch_seq;
    words[0] = 32'h12345678;
    words[1] = 32'hDEADBEEF;
    run_load(2, 0, 1'b1, -1);
    run_load(0, 0, 1'b1, -1);
    fill;
    run_load(5, 1, 1'b0, -1);
    repeat (3) step;
    chk("ovf_hold", 32'(bus.ld_overflow), 32'd1);
    fill;
    run_load(2, 3, 1'b1, -1);
    fill;
    run_load(2, 0, 1'b1, 6);
    repeat (12) begin
      fill;
      run_load($urandom_range(0, 6), $urandom_range(0, 3), 1'b0,
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 23)) : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
